// File: rtl/pacman_pkg.sv
// Shared types and maze constants for the Pac-Man movement logic.
package pacman_pkg;

    localparam int unsigned TILE_PX    = 8;
    localparam int unsigned MAZE_W     = 28;
    localparam int unsigned MAZE_H     = 31;
    localparam int unsigned TUNNEL_ROW = 14;
    localparam int unsigned Y_TILE_OFS = 3;

    typedef enum logic [1:0] {
        DirRight = 2'd0,
        DirUp    = 2'd1,
        DirLeft  = 2'd2,
        DirDown  = 2'd3
    } dir_t;

    typedef enum logic [1:0] {
        TileEmpty  = 2'd0,
        TilePellet = 2'd1,
        TilePower  = 2'd2,
        TileWall   = 2'd3
    } tile_t;

    typedef enum logic [2:0] {
        StIdle,
        StMove,
        StStopped,
        StDying,
        StDead
    } state_t;

    function automatic dir_t opposite(input dir_t d);
        return dir_t'(d ^ 2'b10);
    endfunction

    function automatic tile_t tile_at(input logic [7:0] info, input dir_t d);
        return tile_t'(info[{d, 1'b0} +: 2]);
    endfunction

    // Maze edges count as walls unless the current row is the wrap-around tunnel.
    function automatic logic blocked(input logic [7:0] info, input dir_t d,
                                     input logic [6:0] xtile, input logic tunnel_row);
        logic at_edge;
        at_edge = (d == DirLeft && xtile == 7'd0) ||
                  (d == DirRight && xtile == 7'(MAZE_W - 1));
        return (tile_at(info, d) == TileWall) || (!tunnel_row && at_edge);
    endfunction

endpackage

// File: rtl/pacman_step_div.sv
// Tick generator: one tick every DIV enabled cycles; the count holds while en is low.
module pacman_step_div #(
    parameter int unsigned DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt_q;
    logic          at_top;

    assign at_top = (cnt_q == CW'(DIV - 1));
    assign tick   = en && at_top;

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= at_top ? '0 : cnt_q + CW'(1);
        end
    end

endmodule

// File: rtl/game_pacman.sv
// Pac-Man movement and life controller. Define TUNNEL_WRAP_EN to let the
// tunnel row wrap between x tiles 0 and 27 instead of acting as a wall.
module game_pacman
    import pacman_pkg::*;
#(
    parameter int unsigned START_X     = 13,
    parameter int unsigned START_Y     = 26,
    parameter int unsigned STEP_DIV    = 2,
    parameter int unsigned ANIM_DIV    = 2,
    parameter int unsigned DEATH_TICKS = 90
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [1:0] dir_req,
    input  logic       dir_req_valid,
    input  logic [7:0] tile_info,
    input  logic       ghost_hit,
    output logic [6:0] xtile,
    output logic [6:0] ytile,
    output logic [9:0] xloc,
    output logic [9:0] yloc,
    output logic [1:0] dir,
    output logic [1:0] animation,
    output logic       alive,
    output logic       moving
);

    localparam int unsigned AW    = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
    localparam int unsigned DW    = ($clog2(DEATH_TICKS) > 5) ? $clog2(DEATH_TICKS) : 5;
    localparam int unsigned PX_SH = $clog2(TILE_PX);
    localparam logic signed [3:0] OFF_MAX = 4'sd3;
    localparam logic signed [3:0] OFF_MIN = -4'sd4;
    localparam logic [6:0] X_LAST = 7'(MAZE_W - 1);

    state_t              state_q;
    logic [6:0]          xtile_q, ytile_q;
    logic signed [3:0]   off_q;
    dir_t                dir_q;
    logic [1:0]          anim_q;
    logic                alive_q, moving_q;
    logic                req_pend_q;
    dir_t                req_dir_q;
    logic [AW-1:0]       anim_cnt_q;
    logic [DW-1:0]       death_cnt_q;
    logic [DW-1:0]       death_nxt;

    logic step_tick;
    logic in_tunnel;
    logic live, hit, centre_tick;
    logic dir_blocked, req_blocked;
    logic do_turn, do_stop, do_rev, do_fwd, do_step;

    dir_t              step_dir;
    logic              step_pos, step_horiz;
    logic [6:0]        tile_cur, tile_nxt;
    logic [6:0]        step_x, step_y;
    logic signed [3:0] step_off;

    logic       cur_horiz;
    logic [9:0] off_ext;

    pacman_step_div #(
        .DIV (STEP_DIV)
    ) u_step_div (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .tick (step_tick)
    );

`ifdef TUNNEL_WRAP_EN
    assign in_tunnel = (ytile_q == 7'(TUNNEL_ROW));
`else
    assign in_tunnel = 1'b0;
`endif

    assign dir_blocked = blocked(tile_info, dir_q, xtile_q, in_tunnel);
    assign req_blocked = blocked(tile_info, req_dir_q, xtile_q, in_tunnel);
    assign death_nxt   = death_cnt_q + DW'(1);

    // Event decode; a ghost hit suppresses every movement event in the same cycle.
    always_comb begin
        live        = (state_q == StMove) || (state_q == StStopped);
        hit         = en && ghost_hit && live;
        centre_tick = en && step_tick && (off_q == 4'sd0);
        do_turn     = live && !hit && centre_tick && req_pend_q && !req_blocked;
        do_stop     = (state_q == StMove) && !hit && centre_tick && !do_turn && dir_blocked;
        do_rev      = (state_q == StMove) && !hit && en && !centre_tick && req_pend_q &&
                      (req_dir_q == opposite(dir_q));
        do_fwd      = (state_q == StMove) && !hit && en && step_tick &&
                      !do_turn && !do_stop && !do_rev;
        do_step     = do_turn || do_fwd;
    end

    always_comb begin
        step_dir   = do_turn ? req_dir_q : dir_q;
        step_pos   = (step_dir == DirRight) || (step_dir == DirDown);
        step_horiz = (step_dir == DirRight) || (step_dir == DirLeft);
        tile_cur   = step_horiz ? xtile_q : ytile_q;
        tile_nxt   = tile_cur;
        step_off   = off_q;
        if (step_pos) begin
            if (off_q == OFF_MAX) begin
                tile_nxt = tile_cur + 7'd1;
                step_off = OFF_MIN;
            end else begin
                step_off = off_q + 4'sd1;
            end
        end else begin
            if (off_q == OFF_MIN) begin
                tile_nxt = tile_cur - 7'd1;
                step_off = OFF_MAX;
            end else begin
                step_off = off_q - 4'sd1;
            end
        end
        step_x = step_horiz ? tile_nxt : xtile_q;
        step_y = step_horiz ? ytile_q : tile_nxt;
        if (step_horiz && in_tunnel) begin
            if (step_pos && xtile_q == X_LAST && off_q == OFF_MAX) begin
                step_x = 7'd0;
            end
            if (!step_pos && xtile_q == 7'd0 && off_q == OFF_MIN) begin
                step_x = X_LAST;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= StIdle;
            xtile_q     <= 7'(START_X);
            ytile_q     <= 7'(START_Y);
            off_q       <= 4'sd0;
            dir_q       <= DirLeft;
            anim_q      <= 2'd0;
            alive_q     <= 1'b1;
            moving_q    <= 1'b0;
            req_pend_q  <= 1'b0;
            req_dir_q   <= DirRight;
            anim_cnt_q  <= '0;
            death_cnt_q <= '0;
        end else begin
            if (do_step) begin
                xtile_q <= step_x;
                ytile_q <= step_y;
                off_q   <= step_off;
                if (anim_cnt_q == AW'(ANIM_DIV - 1)) begin
                    anim_cnt_q <= '0;
                    anim_q     <= anim_q + 2'd1;
                end else begin
                    anim_cnt_q <= anim_cnt_q + AW'(1);
                end
            end
            if (do_turn || do_rev) begin
                dir_q      <= req_dir_q;
                req_pend_q <= 1'b0;
            end
            if (en) begin
                unique case (state_q)
                    StIdle: begin
                        state_q  <= StMove;
                        moving_q <= 1'b1;
                    end
                    StMove, StStopped: begin
                        if (hit) begin
                            state_q     <= StDying;
                            alive_q     <= 1'b0;
                            moving_q    <= 1'b0;
                            anim_q      <= 2'd0;
                            death_cnt_q <= '0;
                        end else if (do_stop) begin
                            state_q  <= StStopped;
                            moving_q <= 1'b0;
                        end else if (do_turn) begin
                            state_q  <= StMove;
                            moving_q <= 1'b1;
                        end
                    end
                    StDying: begin
                        if (death_cnt_q == DW'(DEATH_TICKS - 1)) begin
                            state_q <= StDead;
                            anim_q  <= 2'd3;
                        end else begin
                            death_cnt_q <= death_nxt;
                            anim_q      <= death_nxt[4:3];
                        end
                    end
                    StDead: state_q <= StDead;
                    default: state_q <= StIdle;
                endcase
            end
            // A fresh request wins over the clear of the one just consumed.
            if (dir_req_valid) begin
                req_pend_q <= 1'b1;
                req_dir_q  <= dir_t'(dir_req);
            end
        end
    end

    assign cur_horiz = (dir_q == DirRight) || (dir_q == DirLeft);
    assign off_ext   = {{6{off_q[3]}}, off_q};

    assign xloc = ({3'b000, xtile_q} << PX_SH) + 10'd3 + (cur_horiz ? off_ext : 10'd0);
    assign yloc = (({3'b000, ytile_q} + 10'(Y_TILE_OFS)) << PX_SH) + 10'd3 +
                  (cur_horiz ? 10'd0 : off_ext);

    assign xtile     = xtile_q;
    assign ytile     = ytile_q;
    assign dir       = dir_q;
    assign animation = anim_q;
    assign alive     = alive_q;
    assign moving    = moving_q;

endmodule

// File: tb/tb_game_pacman.sv
// Scoreboard bench for game_pacman: a pixel-coordinate reference model predicts
// each cycle's outputs; a monitor compares them after every rising edge.
module tb_game_pacman;

    localparam int START_X     = 13;
    localparam int START_Y     = 26;
    localparam int STEP_DIV    = 2;
    localparam int ANIM_DIV    = 2;
    localparam int DEATH_TICKS = 90;

    localparam int MIdle = 0, MMove = 1, MStop = 2, MDying = 3, MDead = 4;

    logic       clk = 1'b0;
    logic       rst, en, dir_req_valid, ghost_hit;
    logic [1:0] dir_req;
    logic [7:0] tile_info;
    logic [6:0] xtile, ytile;
    logic [9:0] xloc, yloc;
    logic [1:0] dir, animation;
    logic       alive, moving;

    always #5 clk = ~clk;

    game_pacman #(
        .START_X     (START_X),
        .START_Y     (START_Y),
        .STEP_DIV    (STEP_DIV),
        .ANIM_DIV    (ANIM_DIV),
        .DEATH_TICKS (DEATH_TICKS)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .en            (en),
        .dir_req       (dir_req),
        .dir_req_valid (dir_req_valid),
        .tile_info     (tile_info),
        .ghost_hit     (ghost_hit),
        .xtile         (xtile),
        .ytile         (ytile),
        .xloc          (xloc),
        .yloc          (yloc),
        .dir           (dir),
        .animation     (animation),
        .alive         (alive),
        .moving        (moving)
    );

    typedef struct packed {
        logic [6:0] xt;
        logic [6:0] yt;
        logic [9:0] xl;
        logic [9:0] yl;
        logic [1:0] d;
        logic [1:0] an;
        logic       al;
        logic       mv;
    } obs_t;

    obs_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Model keeps Pac-Man's centre as absolute pixels, tile centre at multiples of 8.
    int m_px, m_py, m_dir, m_pend, m_mode, m_encnt, m_steps, m_elapsed;

    function automatic int tile_of(input int p);
        return (p + 4) >>> 3;
    endfunction

    function automatic bit in_tunnel_row();
`ifdef TUNNEL_WRAP_EN
        return (tile_of(m_py) & 127) == 14;
`else
        return 1'b0;
`endif
    endfunction

    function automatic bit m_blocked(input int d);
        int code;
        int xt;
        code = int'(tile_info[2*d +: 2]);
        xt   = tile_of(m_px) & 127;
        if (code == 3) return 1'b1;
        if (!in_tunnel_row() && ((d == 2 && xt == 0) || (d == 0 && xt == 27))) return 1'b1;
        return 1'b0;
    endfunction

    task automatic m_step(input int d);
        case (d)
            0: m_px = m_px + 1;
            1: m_py = m_py - 1;
            2: m_px = m_px - 1;
            default: m_py = m_py + 1;
        endcase
        if (in_tunnel_row()) begin
            if (m_px < -4) m_px = m_px + 224;
            if (m_px > 219) m_px = m_px - 224;
        end
        m_steps++;
    endtask

    task automatic m_cycle(input bit r, input bit e, input bit v, input int req, input bit g);
        bit tick;
        bit centre;
        if (!r) begin
            m_px = START_X * 8; m_py = START_Y * 8; m_dir = 2; m_pend = -1;
            m_mode = MIdle; m_encnt = 0; m_steps = 0; m_elapsed = 0;
        end else begin
            if (e) begin
                tick   = (m_encnt % STEP_DIV) == STEP_DIV - 1;
                m_encnt++;
                centre = (m_px - 8 * tile_of(m_px) == 0) && (m_py - 8 * tile_of(m_py) == 0);
                case (m_mode)
                    MIdle: m_mode = MMove;
                    MMove, MStop: begin
                        if (g) begin
                            m_mode = MDying;
                            m_elapsed = 0;
                        end else if (m_mode == MStop) begin
                            if (tick && m_pend >= 0 && !m_blocked(m_pend)) begin
                                m_dir = m_pend; m_pend = -1; m_step(m_dir); m_mode = MMove;
                            end
                        end else if (tick && centre) begin
                            if (m_pend >= 0 && !m_blocked(m_pend)) begin
                                m_dir = m_pend; m_pend = -1; m_step(m_dir);
                            end else if (m_blocked(m_dir)) begin
                                m_mode = MStop;
                            end else begin
                                m_step(m_dir);
                            end
                        end else if (m_pend == (m_dir + 2) % 4) begin
                            m_dir = m_pend; m_pend = -1;
                        end else if (tick) begin
                            m_step(m_dir);
                        end
                    end
                    MDying: begin
                        m_elapsed++;
                        if (m_elapsed == DEATH_TICKS) m_mode = MDead;
                    end
                    default: ;
                endcase
            end
            if (v) m_pend = req;
        end
    endtask

    function automatic obs_t m_obs();
        obs_t o;
        o.xt = 7'(tile_of(m_px));
        o.yt = 7'(tile_of(m_py));
        o.xl = 10'(m_px + 3);
        o.yl = 10'(m_py + 24 + 3);
        o.d  = 2'(m_dir);
        if (m_mode == MDying)     o.an = 2'((m_elapsed / 8) % 4);
        else if (m_mode == MDead) o.an = 2'd3;
        else                      o.an = 2'((m_steps / ANIM_DIV) % 4);
        o.al = (m_mode != MDying) && (m_mode != MDead);
        o.mv = (m_mode == MMove);
        return o;
    endfunction

    task automatic drive(input bit r, input bit e, input bit v, input int req,
                         input logic [7:0] info, input bit g);
        rst = r; en = e; dir_req_valid = v; dir_req = 2'(req); tile_info = info; ghost_hit = g;
        m_cycle(r, e, v, req, g);
        exp_q.push_back(m_obs());
        @(negedge clk);
    endtask

    function automatic logic [7:0] rand_info(input int wall_pct);
        logic [7:0] t;
        for (int k = 0; k < 4; k++) begin
            if (int'($urandom_range(99)) < wall_pct) t[2*k +: 2] = 2'd3;
            else t[2*k +: 2] = 2'($urandom_range(2));
        end
        return t;
    endfunction

    initial begin : monitor
        obs_t e;
        obs_t got;
        forever begin
            @(posedge clk);
            #2;
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL scoreboard_underflow t=%0t no expected entry", $time);
            end else begin
                e   = exp_q.pop_front();
                got = {xtile, ytile, xloc, yloc, dir, animation, alive, moving};
                if (got === e) begin
                    n_pass++;
                end else begin
                    $display("FAIL outputs t=%0t got xt=%0d yt=%0d xl=%0d yl=%0d d=%0d an=%0d al=%0b mv=%0b required xt=%0d yt=%0d xl=%0d yl=%0d d=%0d an=%0d al=%0b mv=%0b",
                             $time, got.xt, got.yt, got.xl, got.yl, got.d, got.an, got.al,
                             got.mv, e.xt, e.yt, e.xl, e.yl, e.d, e.an, e.al, e.mv);
                end
            end
        end
    end

    initial begin : stimulus
        logic [7:0] info;
        info = 8'h00;
        drive(0, 1, 0, 0, 8'h00, 0);
        drive(0, 1, 0, 0, 8'h00, 0);
        // Open corridor: walk left until the maze edge stops Pac-Man.
        repeat (260) drive(1, 1, 0, 0, 8'h00, 0);
        // Turn up out of STOPPED, then reverse mid-tile.
        drive(1, 1, 1, 1, 8'h00, 0);
        repeat (11) drive(1, 1, 0, 0, 8'h00, 0);
        drive(1, 1, 1, 3, 8'h00, 0);
        repeat (20) drive(1, 1, 0, 0, 8'h00, 0);
        // Blocked request held pending until the wall clears.
        drive(1, 1, 1, 0, 8'hC3, 0);
        repeat (20) drive(1, 1, 0, 0, 8'hC3, 0);
        repeat (20) drive(1, 1, 0, 0, 8'h00, 0);
        // Randomised play with walls, requests, stalls, hits and resets.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(5) == 0) info = rand_info(30);
            drive(($urandom_range(699) != 0), ($urandom_range(9) != 0),
                  ($urandom_range(7) == 0), int'($urandom_range(3)), info,
                  (i > 1500) && ($urandom_range(599) == 0));
        end
        // Directed death: hit, full dying sequence, hits in DEAD ignored, then reset.
        drive(0, 1, 0, 0, 8'h00, 0);
        repeat (17) drive(1, 1, 0, 0, 8'h00, 0);
        drive(1, 1, 0, 0, 8'h00, 1);
        repeat (130) drive(1, ($urandom_range(7) != 0), 0, 0, 8'h00, ($urandom_range(4) == 0));
        drive(0, 1, 0, 0, 8'h00, 0);
        repeat (10) drive(1, 1, 0, 0, 8'h00, 0);
        #3;
        n_checks++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL scoreboard_drain left=%0d required=0", exp_q.size());
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
